player_physics: RTL

- Second-generation player motion block: parametrised horizontal patrol with wall bounce, plus vertical physics (gravity, jump, floor landing, ceiling bump) and hazard death/respawn.
- Advances one motion tick per sim_clk edge; sim_clk is the game-tick clock from the timing block.
- Consumes per-tick collision flags from the tile collision checker. Drives packed position to the renderer/collision path.

---
 rtl/player_physics.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/player_physics.sv
// player_physics: per-tick player motion.
// Horizontal patrol with wall bounce and tile snap, vertical gravity/jump with
// floor landing and ceiling bump, hazard death with timed respawn.
// Ports:
//   sim_clk    game-tick clock, all state advances on its rising edge
//   rst        synchronous active-high reset
//   jump       jump request (level), honoured only while grounded
//   playerCol  [0] wall ahead, [1] floor below, [2] ceiling above, [3] hazard
//   playerPos  {xPos, yPos}, registered
//   playerDir  0 = left, 1 = right, registered
//   grounded   high in GROUND, registered
//   dead       high in DEAD, registered
module player_physics #(
    parameter int unsigned POS_W         = 10,
    parameter int unsigned VEL_W         = 6,
    parameter int unsigned TILE_LOG2     = 5,
    parameter int unsigned X_ORIGIN      = 144,
    parameter int unsigned Y_ORIGIN      = 35,
    parameter int unsigned X_INIT        = 200,
    parameter int unsigned Y_INIT        = 300,
    parameter int unsigned WALK_SPEED    = 3,
    parameter int unsigned JUMP_SPEED    = 12,
    parameter int unsigned GRAVITY       = 1,
    parameter int unsigned MAX_FALL      = 8,
    parameter int unsigned RESPAWN_TICKS = 4
) (
    input  logic                 sim_clk,
    input  logic                 rst,
    input  logic                 jump,
    input  logic [3:0]           playerCol,
    output logic [2*POS_W-1:0]   playerPos,
    output logic                 playerDir,
    output logic                 grounded,
    output logic                 dead
);

    localparam int unsigned TILE  = 1 << TILE_LOG2;
    localparam int unsigned CNT_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;

    localparam logic [POS_W-1:0]        TILE_MASK  = POS_W'(TILE - 1);
    localparam logic [POS_W-1:0]        TILE_SIZE  = POS_W'(TILE);
    localparam logic signed [VEL_W-1:0] MAX_FALL_V = VEL_W'(MAX_FALL);
    localparam logic signed [VEL_W-1:0] GRAVITY_V  = VEL_W'(GRAVITY);
    localparam logic signed [VEL_W-1:0] JUMP_V     = VEL_W'(JUMP_SPEED);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2,
        DEAD   = 2'd3
    } stateT;

    stateT                     state, stateNext;
    logic [POS_W-1:0]          xPos, xNext;
    logic [POS_W-1:0]          yPos, yNext;
    logic signed [VEL_W-1:0]   vy, vyNext;
    logic [CNT_W-1:0]          cnt, cntNext;
    logic                      dirNext;
    logic                      groundedNext, deadNext;

    logic [POS_W-1:0]          fx, fy, vyExt;
    logic signed [VEL_W-1:0]   vyInc;

    // Offsets within the current tile, and velocity helpers
    always_comb begin
        fx    = (xPos - POS_W'(X_ORIGIN)) & TILE_MASK;
        fy    = (yPos - POS_W'(Y_ORIGIN)) & TILE_MASK;
        vyExt = {{(POS_W - VEL_W){vy[VEL_W-1]}}, vy};
        vyInc = vy + GRAVITY_V;
    end

    // Next-state and next-output logic
    always_comb begin
        stateNext = state;
        xNext     = xPos;
        yNext     = yPos;
        vyNext    = vy;
        cntNext   = cnt;
        dirNext   = playerDir;

        if (state == DEAD) begin
            if (cnt == '0) begin
                xNext     = POS_W'(X_INIT);
                yNext     = POS_W'(Y_INIT);
                dirNext   = 1'b1;
                vyNext    = '0;
                stateNext = FALL;
            end else begin
                cntNext = cnt - CNT_W'(1);
            end
        end else if (playerCol[3]) begin
            stateNext = DEAD;
            cntNext   = CNT_W'(RESPAWN_TICKS - 1);
            vyNext    = '0;
        end else begin
            // Wall hit snaps to the tile edge and reverses instead of stepping
            if (playerCol[0]) begin
                if (playerDir) xNext = xPos - fx - POS_W'(1);
                else           xNext = xPos + (TILE_SIZE - fx);
                dirNext = ~playerDir;
            end else if (playerDir) begin
                xNext = xPos + POS_W'(WALK_SPEED);
            end else begin
                xNext = xPos - POS_W'(WALK_SPEED);
            end

            case (state)
                GROUND: begin
                    if (jump) begin
                        vyNext    = -JUMP_V;
                        stateNext = RISE;
                    end else if (!playerCol[1]) begin
                        vyNext    = '0;
                        stateNext = FALL;
                    end
                end
                RISE: begin
                    if (playerCol[2]) begin
                        yNext     = yPos + (TILE_SIZE - fy);
                        vyNext    = '0;
                        stateNext = FALL;
                    end else begin
                        yNext  = yPos + vyExt;
                        vyNext = vyInc;
                        if (!vyInc[VEL_W-1]) stateNext = FALL;
                    end
                end
                FALL: begin
                    if (playerCol[1]) begin
                        yNext     = yPos - fy;
                        vyNext    = '0;
                        stateNext = GROUND;
                    end else begin
                        yNext  = yPos + vyExt;
                        vyNext = (vyInc > MAX_FALL_V) ? MAX_FALL_V : vyInc;
                    end
                end
                default: ;
            endcase
        end

        groundedNext = (stateNext == GROUND);
        deadNext     = (stateNext == DEAD);
    end

    // State and output registers
    always_ff @(posedge sim_clk) begin
        if (rst) begin
            state     <= FALL;
            xPos      <= POS_W'(X_INIT);
            yPos      <= POS_W'(Y_INIT);
            vy        <= '0;
            cnt       <= '0;
            playerDir <= 1'b1;
            grounded  <= 1'b0;
            dead      <= 1'b0;
        end else begin
            state     <= stateNext;
            xPos      <= xNext;
            yPos      <= yNext;
            vy        <= vyNext;
            cnt       <= cntNext;
            playerDir <= dirNext;
            grounded  <= groundedNext;
            dead      <= deadNext;
        end
    end

    assign playerPos = {xPos, yPos};

endmodule
